// File: rtl/led_pattern_scheduler_pkg.sv
// Shared definitions for the LED pattern scheduler: pattern codes, LED width
// and the per-pattern LED encodings.
package led_pkg;

    localparam int LED_W = 8;

    typedef enum logic [1:0] {
        PAT_CHECK = 2'd0,
        PAT_SCAN  = 2'd1,
        PAT_COUNT = 2'd2,
        PAT_BAR   = 2'd3
    } pat_e;

    function automatic logic [LED_W-1:0] scan_mask(input logic [2:0] pos);
        return 8'd1 << pos;
    endfunction

    // Level 8 lights every LED, so the mask is formed one bit wider before truncating.
    function automatic logic [LED_W-1:0] bar_mask(input logic [3:0] level);
        logic [LED_W:0] m;
        m = (9'd1 << level) - 9'd1;
        return m[LED_W-1:0];
    endfunction

endpackage

// File: rtl/led_pattern_scheduler_step_gen.sv
// Animation prescaler: counts 0..DIVISOR-1 while enabled and flags the last count
// as a step; a synchronous clear restarts the period.
module step_gen #(
    parameter int unsigned DIVISOR = 32'd50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_step
);

    localparam int unsigned CW = (DIVISOR > 32'd1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 32'd1);

    logic [CW-1:0] r_cnt;
    logic          w_hit;

    assign w_hit  = (r_cnt == LAST);
    assign o_step = w_hit & i_en;

    // Prescaler count; clear wins over counting, pause holds the value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (w_hit) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1'b1);
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/led_pattern_scheduler.sv
// Drives the 8 board LEDs through CHECK/SCAN/COUNT/BAR animations, advancing the
// pattern on a button edge or, in auto mode, after DWELL animation steps.
module led_pattern_scheduler
    import led_pkg::*;
#(
    parameter int unsigned DIVISOR = 32'd50000000,
    parameter int unsigned DWELL   = 32'd16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_next,
    input  logic             auto_mode,
    input  logic             pause,
    output logic [LED_W-1:0] led,
    output logic [1:0]       pattern_id,
    output logic             step
);

    localparam int unsigned DW_W = $clog2(DWELL + 32'd1);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 32'd1);

    logic             w_step;
    logic             w_btn_edge;
    logic             w_auto_adv;
    logic             w_advance;
    logic             w_en;

    pat_e             r_pat,   w_pat_nxt;
    logic             r_btn_prev;
    logic [DW_W-1:0]  r_dwell, w_dwell_nxt;
    logic             r_chk,   w_chk_nxt;
    logic [2:0]       r_pos,   w_pos_nxt;
    logic             r_up,    w_up_nxt;
    logic [7:0]       r_cnt,   w_cnt_nxt;
    logic [3:0]       r_lvl,   w_lvl_nxt;
    logic [LED_W-1:0] r_led,   w_led_nxt;

    assign w_en       = ~pause;
    assign w_btn_edge = btn_next & ~r_btn_prev;
    assign w_auto_adv = w_step & auto_mode & (r_dwell == DWELL_LAST);
    // A button edge coinciding with an auto advance still yields a single advance.
    assign w_advance  = w_btn_edge | w_auto_adv;

    step_gen #(
        .DIVISOR(DIVISOR)
    ) u_step_gen (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_en),
        .i_clr (w_advance),
        .o_step(w_step)
    );

    // State register: pattern, per-pattern animation state, dwell, button history, LED drive.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pat      <= PAT_CHECK;
            r_btn_prev <= 1'b1;
            r_dwell    <= '0;
            r_chk      <= 1'b0;
            r_pos      <= 3'd0;
            r_up       <= 1'b1;
            r_cnt      <= 8'd0;
            r_lvl      <= 4'd0;
            r_led      <= 8'h55;
        end else begin
            r_pat      <= w_pat_nxt;
            r_btn_prev <= btn_next;
            r_dwell    <= w_dwell_nxt;
            r_chk      <= w_chk_nxt;
            r_pos      <= w_pos_nxt;
            r_up       <= w_up_nxt;
            r_cnt      <= w_cnt_nxt;
            r_lvl      <= w_lvl_nxt;
            r_led      <= w_led_nxt;
        end
    end

    // Next-state logic: an advance reloads initial state and drops that cycle's step.
    always_comb begin
        w_pat_nxt = r_pat;
        w_chk_nxt = r_chk;
        w_pos_nxt = r_pos;
        w_up_nxt  = r_up;
        w_cnt_nxt = r_cnt;
        w_lvl_nxt = r_lvl;
        if (w_advance) begin
            w_pat_nxt = pat_e'(r_pat + 2'd1);
            w_chk_nxt = 1'b0;
            w_pos_nxt = 3'd0;
            w_up_nxt  = 1'b1;
            w_cnt_nxt = 8'd0;
            w_lvl_nxt = 4'd0;
        end else if (w_step) begin
            case (r_pat)
                PAT_CHECK: w_chk_nxt = ~r_chk;
                PAT_SCAN: begin
                    if (r_up) begin
                        if (r_pos == 3'd7) begin
                            w_pos_nxt = 3'd6;
                            w_up_nxt  = 1'b0;
                        end else begin
                            w_pos_nxt = r_pos + 3'd1;
                        end
                    end else begin
                        if (r_pos == 3'd0) begin
                            w_pos_nxt = 3'd1;
                            w_up_nxt  = 1'b1;
                        end else begin
                            w_pos_nxt = r_pos - 3'd1;
                        end
                    end
                end
                PAT_COUNT: w_cnt_nxt = r_cnt + 8'd1;
                PAT_BAR:   w_lvl_nxt = (r_lvl == 4'd8) ? 4'd0 : r_lvl + 4'd1;
                default:   w_chk_nxt = r_chk;
            endcase
        end else begin
            w_pat_nxt = r_pat;
        end

        if (!auto_mode || w_advance) begin
            w_dwell_nxt = '0;
        end else if (w_step) begin
            w_dwell_nxt = r_dwell + DW_W'(1'b1);
        end else begin
            w_dwell_nxt = r_dwell;
        end
    end

    // Output logic: LED image of the next state, registered into r_led.
    always_comb begin
        case (w_pat_nxt)
            PAT_CHECK: w_led_nxt = w_chk_nxt ? 8'hAA : 8'h55;
            PAT_SCAN:  w_led_nxt = scan_mask(w_pos_nxt);
            PAT_COUNT: w_led_nxt = w_cnt_nxt;
            PAT_BAR:   w_led_nxt = bar_mask(w_lvl_nxt);
            default:   w_led_nxt = 8'h55;
        endcase
    end

    assign led        = r_led;
    assign pattern_id = r_pat;
    assign step       = w_step;

endmodule
